imm_issue_ctrl: RTL and testbench
=================================

Name: imm_issue_ctrl

Overview:
- ID-stage controller that sequences immediate extension for the pipeline.
- Decodes the opcode of each issued instruction and selects the extension mode: sign, zero, upper (LUI) or branch-offset.
- Forms the 32-bit immediate and delivers it to the ID/EX boundary through a 2-entry valid/ready skid buffer.
- Supports stall back-pressure and a pipeline flush.

Parameters:
- FP_MEM_EN, 1: when 1, lwc1 (0x31) and swc1 (0x39) decode as SIGN; when 0 they decode as NONE.
- BR_SHIFT, 2: left-shift amount applied to sign-extended branch offsets; legal range 0..3.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  block can accept an instruction this cycle.
- instr  input  32  instruction word; opcode is instr[31:26], immediate is instr[15:0].
- flush  input  1  discard all buffered entries (branch taken or exception).
- out_valid  output  1  out_imm, out_mode and out_used are valid.
- out_ready  input  1  downstream (ID/EX) accepts this cycle.
- out_imm  output  32  extended immediate.
- out_mode  output  3  mode code: 0 NONE, 1 SIGN, 2 ZERO, 3 UPPER, 4 BRANCH.
- out_used  output  1  1 when the instruction consumes an immediate (mode != NONE).
- occupancy  output  2  number of buffered entries, 0..2.

Behaviour:
- Reset (asynchronous, rst_n=0): both entries invalid; out_valid=0, out_imm=0, out_mode=0, out_used=0, occupancy=0, in_ready=1. Effect is immediate; deassertion takes effect at the next clk edge.
- Decode (combinational on instr):
  - SIGN for 0x08, 0x09, 0x0A, 0x0B, 0x23, 0x2B, and 0x31/0x39 when FP_MEM_EN=1. Value = {16{imm[15]}, imm}.
  - ZERO for 0x0C, 0x0D, 0x0E. Value = {16'h0000, imm}.
  - UPPER for 0x0F. Value = {imm, 16'h0000}.
  - BRANCH for 0x04, 0x05. Value = sign-extended imm shifted left by BR_SHIFT, truncated to 32 bits.
  - NONE for all other opcodes (R-type 0x00, j 0x02, etc.). Value = 0, out_used=0.
- Storage: head register (drives the outputs) plus one skid register.
- in_ready = (occupancy < 2), driven from registered state only; no combinational path from out_ready.
- Accept: in_valid & in_ready at the clk edge.
  - If occupancy was 0, or was 1 and the head pops the same cycle, the new entry goes to head.
  - Otherwise it goes to skid.
- Pop: out_valid & out_ready at the clk edge.
  - If skid is valid, skid moves to head.
  - If no push occurs and skid is empty, head becomes invalid.
- Simultaneous push and pop:
  - At occupancy 1: head is replaced by the new entry; occupancy stays 1.
  - At occupancy 2: in_ready=0, so no push; pop moves skid to head; occupancy becomes 1.
- Latency: an instruction accepted into an empty buffer appears at the outputs the next cycle (1-cycle latency).
- Throughput: 1 instruction per cycle while out_ready=1.
- Stall: with out_ready=0, out_imm, out_mode and out_used hold stable until the pop.
- Flush (synchronous, highest priority):
  - At the clk edge, both entries are invalidated and occupancy becomes 0.
  - Any same-cycle push is discarded and any same-cycle pop is ignored.
  - Next cycle: out_valid=0, in_ready=1.
- Invalid outputs: when out_valid=0, out_imm=0, out_mode=0, out_used=0.
- occupancy never exceeds 2.
- No action is taken on in_valid while in_ready=0; upstream must hold instr stable.

Test Plan:
- Reset mid-stream: occupancy=2, then rst_n low → outputs zero and in_ready=1 immediately, with no clk edge required.
- Mode decode, out_ready=1:
  - addi imm 0xFFF0 → 0xFFFFFFF0, SIGN.
  - ori 0x8001 → 0x00008001, ZERO.
  - lui 0x1234 → 0x12340000, UPPER.
  - beq 0xFFFF → 0xFFFFFFFC, BRANCH.
  - R-type → 0, NONE, out_used=0.
- Back-pressure: out_ready=0, push 3 instrs (lw 0x0004, lw 0x0008, lw 0x000C).
  - After 2 accepts, occupancy=2 and in_ready=0; third is held upstream.
  - Release out_ready → order 0x4, 0x8, 0xC with no loss or duplication.
- Simultaneous push+pop at occupancy 1: steady stream of 4 instrs with out_ready=1 → one output per cycle, occupancy remains 1.
- Flush with occupancy=2 and in_valid=1 → next cycle out_valid=0, occupancy=0; the flushed-cycle instruction never appears at the outputs.
- FP_MEM_EN=0: lwc1 imm 0x8000 → NONE, out_imm=0. FP_MEM_EN=1: same instr → 0xFFFF8000, SIGN.

Source files
------------

// File: rtl/imm_issue_ctrl.sv
// imm_issue_ctrl: ID-stage immediate extension with a 2-entry valid/ready
// skid buffer (head register drives the outputs, skid absorbs one extra).
module imm_issue_ctrl #(
  parameter bit          FP_MEM_EN = 1'b1,
  parameter int unsigned BR_SHIFT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_imm,
  output logic [2:0]  out_mode,
  output logic        out_used,
  output logic [1:0]  occupancy
);

  localparam logic [2:0] MODE_NONE   = 3'd0;
  localparam logic [2:0] MODE_SIGN   = 3'd1;
  localparam logic [2:0] MODE_ZERO   = 3'd2;
  localparam logic [2:0] MODE_UPPER  = 3'd3;
  localparam logic [2:0] MODE_BRANCH = 3'd4;

  logic [31:0] sext_s;
  logic [31:0] dec_imm_s;
  logic [2:0]  dec_mode_s;
  logic        unused_instr_s;

  logic        head_valid_r, head_used_r, skid_valid_r, skid_used_r;
  logic [31:0] head_imm_r, skid_imm_r;
  logic [2:0]  head_mode_r, skid_mode_r;

  logic        head_valid_nxt_s, head_used_nxt_s, skid_valid_nxt_s, skid_used_nxt_s;
  logic [31:0] head_imm_nxt_s, skid_imm_nxt_s;
  logic [2:0]  head_mode_nxt_s, skid_mode_nxt_s;

  logic        push_s;
  logic        pop_s;

  // Register fields between the opcode and the immediate do not affect extension.
  assign unused_instr_s = ^instr[25:16];

  assign sext_s = {{16{instr[15]}}, instr[15:0]};

  // Opcode decode: pick the extension mode and form the 32-bit immediate.
  always_comb begin
    dec_mode_s = MODE_NONE;
    dec_imm_s  = 32'h0000_0000;
    case (instr[31:26])
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
        dec_mode_s = MODE_SIGN;
        dec_imm_s  = sext_s;
      end
      6'h31, 6'h39: begin
        if (FP_MEM_EN) begin
          dec_mode_s = MODE_SIGN;
          dec_imm_s  = sext_s;
        end else begin
          dec_mode_s = MODE_NONE;
          dec_imm_s  = 32'h0000_0000;
        end
      end
      6'h0C, 6'h0D, 6'h0E: begin
        dec_mode_s = MODE_ZERO;
        dec_imm_s  = {16'h0000, instr[15:0]};
      end
      6'h0F: begin
        dec_mode_s = MODE_UPPER;
        dec_imm_s  = {instr[15:0], 16'h0000};
      end
      6'h04, 6'h05: begin
        dec_mode_s = MODE_BRANCH;
        dec_imm_s  = sext_s << BR_SHIFT;
      end
      default: begin
        dec_mode_s = MODE_NONE;
        dec_imm_s  = 32'h0000_0000;
      end
    endcase
  end

  // Skid is only ever occupied while head is, so "not full" is simply "skid empty".
  assign in_ready = ~skid_valid_r;
  assign push_s   = in_valid & in_ready;
  assign pop_s    = head_valid_r & out_ready;

  // Next-state of the two entries: flush first, then pop/refill, then plain push.
  always_comb begin
    head_valid_nxt_s = head_valid_r;
    head_imm_nxt_s   = head_imm_r;
    head_mode_nxt_s  = head_mode_r;
    head_used_nxt_s  = head_used_r;
    skid_valid_nxt_s = skid_valid_r;
    skid_imm_nxt_s   = skid_imm_r;
    skid_mode_nxt_s  = skid_mode_r;
    skid_used_nxt_s  = skid_used_r;
    if (flush) begin
      // Clearing head data keeps the outputs at zero while invalid.
      head_valid_nxt_s = 1'b0;
      head_imm_nxt_s   = 32'h0000_0000;
      head_mode_nxt_s  = MODE_NONE;
      head_used_nxt_s  = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else if (pop_s) begin
      if (skid_valid_r) begin
        head_imm_nxt_s   = skid_imm_r;
        head_mode_nxt_s  = skid_mode_r;
        head_used_nxt_s  = skid_used_r;
        skid_valid_nxt_s = 1'b0;
      end else if (push_s) begin
        head_imm_nxt_s   = dec_imm_s;
        head_mode_nxt_s  = dec_mode_s;
        head_used_nxt_s  = (dec_mode_s != MODE_NONE);
      end else begin
        head_valid_nxt_s = 1'b0;
        head_imm_nxt_s   = 32'h0000_0000;
        head_mode_nxt_s  = MODE_NONE;
        head_used_nxt_s  = 1'b0;
      end
    end else if (push_s) begin
      if (head_valid_r) begin
        skid_valid_nxt_s = 1'b1;
        skid_imm_nxt_s   = dec_imm_s;
        skid_mode_nxt_s  = dec_mode_s;
        skid_used_nxt_s  = (dec_mode_s != MODE_NONE);
      end else begin
        head_valid_nxt_s = 1'b1;
        head_imm_nxt_s   = dec_imm_s;
        head_mode_nxt_s  = dec_mode_s;
        head_used_nxt_s  = (dec_mode_s != MODE_NONE);
      end
    end else begin
      head_valid_nxt_s = head_valid_r;
    end
  end

  // Entry storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid_r <= 1'b0;
      head_imm_r   <= 32'h0000_0000;
      head_mode_r  <= MODE_NONE;
      head_used_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_imm_r   <= 32'h0000_0000;
      skid_mode_r  <= MODE_NONE;
      skid_used_r  <= 1'b0;
    end else begin
      head_valid_r <= head_valid_nxt_s;
      head_imm_r   <= head_imm_nxt_s;
      head_mode_r  <= head_mode_nxt_s;
      head_used_r  <= head_used_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      skid_imm_r   <= skid_imm_nxt_s;
      skid_mode_r  <= skid_mode_nxt_s;
      skid_used_r  <= skid_used_nxt_s;
    end
  end

  assign out_valid = head_valid_r;
  assign out_imm   = head_imm_r;
  assign out_mode  = head_mode_r;
  assign out_used  = head_used_r;
  assign occupancy = {skid_valid_r, head_valid_r & ~skid_valid_r};

endmodule

// File: tb/tb_imm_issue_ctrl.sv
// Scoreboard bench for imm_issue_ctrl: two instances (FP_MEM_EN=1 and 0) share
// stimulus; a negedge monitor compares both against a queue-based reference.
module tb_imm_issue_ctrl;

  localparam int BRS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_used;
  logic [31:0] out_imm;
  logic [2:0]  out_mode;
  logic [1:0]  occupancy;
  logic        in_ready0, out_valid0, out_used0;
  logic [31:0] out_imm0;
  logic [2:0]  out_mode0;
  logic [1:0]  occupancy0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] imm1;
    logic [2:0]  mode1;
    logic [31:0] imm0;
    logic [2:0]  mode0;
  } exp_t;
  exp_t q[$];

  imm_issue_ctrl #(.FP_MEM_EN(1'b1), .BR_SHIFT(BRS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_mode(out_mode), .out_used(out_used), .occupancy(occupancy)
  );

  imm_issue_ctrl #(.FP_MEM_EN(1'b0), .BR_SHIFT(BRS)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .instr(instr), .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
    .out_imm(out_imm0), .out_mode(out_mode0), .out_used(out_used0), .occupancy(occupancy0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: mode and value straight from the opcode lists and arithmetic.
  function automatic void ref_model(input logic [31:0] ins, input bit fp,
                                    output logic [31:0] imm, output logic [2:0] mode);
    int op, lo, sx;
    op = int'(ins[31:26]);
    lo = int'(ins[15:0]);
    sx = (lo >= 32768) ? lo - 65536 : lo;
    imm = 32'h0;
    mode = 3'd0;
    if (op inside {8, 9, 10, 11, 35, 43} || (fp && op inside {49, 57})) begin
      mode = 3'd1; imm = sx;
    end else if (op inside {12, 13, 14}) begin
      mode = 3'd2; imm = lo;
    end else if (op == 15) begin
      mode = 3'd3; imm = lo * 65536;
    end else if (op inside {4, 5}) begin
      mode = 3'd4; imm = sx * (1 << BRS);
    end
  endfunction

  // Monitor: inputs are stable at the falling edge, so this sees exactly what
  // the next rising edge will act on.
  exp_t e_m;
  int   occ_m;
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      occ_m = q.size();
      chk("occupancy", 32'(occupancy), 32'(occ_m));
      chk("in_ready", 32'(in_ready), 32'(occ_m < 2));
      chk("out_valid", 32'(out_valid), 32'(occ_m > 0));
      chk("out_valid_fp0", 32'(out_valid0), 32'(occ_m > 0));
      if (occ_m > 0) begin
        e_m = q[0];
        chk("imm", out_imm, e_m.imm1);
        chk("mode", 32'(out_mode), 32'(e_m.mode1));
        chk("used", 32'(out_used), 32'(e_m.mode1 != 3'd0));
        chk("imm_fp0", out_imm0, e_m.imm0);
        chk("mode_fp0", 32'(out_mode0), 32'(e_m.mode0));
        if (out_ready && !flush) void'(q.pop_front());
      end else begin
        chk("idle_outs", {out_imm[31:4] | out_imm[3:0], out_mode, out_used}, 32'h0);
      end
      if (flush) begin
        q.delete();
      end else if (in_valid && occ_m < 2) begin
        ref_model(instr, 1'b1, e_m.imm1, e_m.mode1);
        ref_model(instr, 1'b0, e_m.imm0, e_m.mode0);
        q.push_back(e_m);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] d_ins [6];
  logic [31:0] d_imm [6];
  logic [2:0]  d_mode[6];
  logic [31:0] d_imm0[6];
  int          ops[16];
  logic [31:0] r;
  int          op;
  bit          hold;

  initial begin
    d_ins[0] = {6'h08, 10'h021, 16'hFFF0}; d_imm[0] = 32'hFFFF_FFF0; d_mode[0] = 3'd1; d_imm0[0] = 32'hFFFF_FFF0;
    d_ins[1] = {6'h0D, 10'h021, 16'h8001}; d_imm[1] = 32'h0000_8001; d_mode[1] = 3'd2; d_imm0[1] = 32'h0000_8001;
    d_ins[2] = {6'h0F, 10'h001, 16'h1234}; d_imm[2] = 32'h1234_0000; d_mode[2] = 3'd3; d_imm0[2] = 32'h1234_0000;
    d_ins[3] = {6'h04, 10'h022, 16'hFFFF}; d_imm[3] = 32'hFFFF_FFFC; d_mode[3] = 3'd4; d_imm0[3] = 32'hFFFF_FFFC;
    d_ins[4] = 32'h012A_4020;              d_imm[4] = 32'h0000_0000; d_mode[4] = 3'd0; d_imm0[4] = 32'h0000_0000;
    d_ins[5] = {6'h31, 10'h022, 16'h8000}; d_imm[5] = 32'hFFFF_8000; d_mode[5] = 3'd1; d_imm0[5] = 32'h0000_0000;
    ops = '{0, 2, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 35, 43, 49, 57};

    // Reset state
    #3;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_imm", out_imm, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_occ", 32'(occupancy), 32'h0);
    @(posedge clk); cycle();
    rst_n = 1'b1;
    cycle();

    // Mode decode streamed with out_ready=1: one output per cycle at occupancy 1
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      instr = d_ins[i];
      cycle();
      chk("dec_imm", out_imm, d_imm[i]);
      chk("dec_mode", 32'(out_mode), 32'(d_mode[i]));
      chk("dec_used", 32'(out_used), 32'(d_mode[i] != 3'd0));
      chk("dec_imm_fp0", out_imm0, d_imm0[i]);
      chk("stream_occ", 32'(occupancy), 32'h1);
    end
    chk("lwc1_mode_fp0", 32'(out_mode0), 32'h0);
    in_valid = 1'b0;
    cycle();
    chk("drained", 32'(out_valid), 32'h0);

    // Back-pressure: three lw with out_ready=0, third held upstream
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = {6'h23, 10'h001, 16'h0004}; cycle();
    instr = {6'h23, 10'h001, 16'h0008}; cycle();
    chk("bp_occ2", 32'(occupancy), 32'h2);
    chk("bp_not_ready", 32'(in_ready), 32'h0);
    instr = {6'h23, 10'h001, 16'h000C}; cycle(); cycle();
    chk("bp_stall_imm", out_imm, 32'h4);
    out_ready = 1'b1;
    chk("bp_first", out_imm, 32'h4);
    cycle();
    chk("bp_second", out_imm, 32'h8);
    cycle();
    in_valid = 1'b0;
    chk("bp_third", out_imm, 32'hC);
    cycle();
    chk("bp_empty", 32'(out_valid), 32'h0);

    // Reset mid-stream at occupancy 2, no clock edge needed
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = {6'h0E, 10'h0, 16'h00AA}; cycle();
    instr = {6'h0F, 10'h0, 16'h00BB}; cycle();
    in_valid = 1'b0;
    chk("pre_rst_occ", 32'(occupancy), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_outs", {out_imm[31:4] | out_imm[3:0], out_mode, out_used}, 32'h0);
    chk("arst_occ", 32'(occupancy), 32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'h1);
    cycle();
    rst_n = 1'b1;
    cycle();

    // Flush at occupancy 2 with in_valid=1
    in_valid = 1'b1;
    instr = {6'h09, 10'h0, 16'h1111}; cycle();
    instr = {6'h09, 10'h0, 16'h2222}; cycle();
    instr = {6'h09, 10'h0, 16'h3333};
    flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_occ", 32'(occupancy), 32'h0);
    chk("flush_in_ready", 32'(in_ready), 32'h1);
    // Flush at occupancy 1 discards the same-cycle push too
    in_valid = 1'b1;
    instr = {6'h0C, 10'h0, 16'h4444}; cycle();
    instr = {6'h0C, 10'h0, 16'h5555};
    flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_occ", 32'(occupancy), 32'h0);
    out_ready = 1'b1;
    repeat (3) cycle();

    // Randomized traffic; upstream holds instr while not accepted
    hold = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      out_ready = ($urandom % 4) != 0;
      flush = ($urandom % 20) == 0;
      if (!hold) begin
        in_valid = ($urandom % 3) != 0;
        r = $urandom;
        op = (($urandom % 4) == 0) ? int'($urandom_range(0, 63)) : ops[$urandom_range(0, 15)];
        instr = {6'(op), r[25:0]};
      end
      hold = in_valid && !in_ready && !flush;
      cycle();
    end

    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();
    chk("final_empty", 32'(occupancy), 32'h0);
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
